// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with a shared slave port, slave
// decode on address bits [31:30] and a per-access ready timeout.
module bus_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned RESET_PTR   = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   m_req,
  input  logic [3:0]   m_as,
  input  logic [3:0]   m_rw,
  input  logic [127:0] m_addr,
  input  logic [127:0] m_wr_data,
  output logic [3:0]   m_grnt,
  output logic         m_rdy,
  output logic         m_err,
  output logic [31:0]  m_rd_data,
  output logic         s_as,
  output logic         s_rw,
  output logic [31:0]  s_addr,
  output logic [31:0]  s_wr_data,
  output logic [3:0]   s_cs,
  input  logic [3:0]   s_rdy,
  input  logic [127:0] s_rd_data
);

  localparam int unsigned NM = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {IDLE, OWNED, ACCESS} state_e;

  state_e          state_q, state_d;
  logic [1:0]      owner_q, owner_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NM-1:0]   grnt_q, grnt_d;

  logic            own_req, own_as;
  logic [1:0]      sel;
  logic            rdy_sel, timed_out, done;
  logic            win_found;
  logic [1:0]      win, cand;

  assign m_grnt = grnt_q;

  // Shared slave bus mux, slave decode and completion response
  always_comb begin : bus_mux
    s_as      = 1'b0;
    s_rw      = 1'b0;
    s_addr    = '0;
    s_wr_data = '0;
    s_cs      = '0;
    own_req   = m_req[owner_q];
    own_as    = m_as[owner_q];
    if (state_q != IDLE && own_req && own_as) begin
      s_as      = 1'b1;
      s_rw      = m_rw[owner_q];
      s_addr    = m_addr[{owner_q, 5'd0} +: DW];
      s_wr_data = m_wr_data[{owner_q, 5'd0} +: DW];
    end
    sel = s_addr[31:30];
    if (s_as) s_cs = 4'b0001 << sel;
    rdy_sel   = s_rdy[sel];
    timed_out = (cnt_q == CW'(TIMEOUT_CYC - 1));
    done      = (state_q == ACCESS) && s_as && (rdy_sel || timed_out);
    m_rdy     = done;
    m_err     = done && !rdy_sel;
    m_rd_data = (done && rdy_sel && !s_rw) ? s_rd_data[{sel, 5'd0} +: DW] : '0;
  end

  // Arbitration and ownership state machine
  always_comb begin : fsm_next
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    grnt_d    = grnt_q;
    win_found = 1'b0;
    win       = '0;
    cand      = '0;
    // search order ptr+1, ptr+2, ptr+3, ptr (k=4 wraps back to ptr)
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!win_found && m_req[cand]) begin
        win_found = 1'b1;
        win       = cand;
      end
    end
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grnt_d  = 4'b0001 << win;
          owner_d = win;
          ptr_d   = win;
          state_d = OWNED;
        end else begin
          grnt_d = '0;
        end
      end
      OWNED: begin
        if (!own_req) begin
          grnt_d  = '0;
          state_d = IDLE;
        end else if (own_as) begin
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!own_req) begin
          grnt_d  = '0;
          state_d = IDLE;
        end else if (!own_as || done) begin
          state_d = OWNED;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        grnt_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= 2'(RESET_PTR);
      cnt_q   <= '0;
      grnt_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grnt_q  <= grnt_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_bus_arbiter;

  localparam int TO = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   m_req, m_as, m_rw;
  logic [127:0] m_addr, m_wr_data;
  logic [3:0]   m_grnt;
  logic         m_rdy, m_err;
  logic [31:0]  m_rd_data;
  logic         s_as, s_rw;
  logic [31:0]  s_addr, s_wr_data;
  logic [3:0]   s_cs, s_rdy;
  logic [127:0] s_rd_data;

  int checks   = 0;
  int failures = 0;

  // reference model: bus held?, holder, last winner, cycles waited (-1 = no access)
  bit mg;
  int mo, ml, mw;

  // DUT values captured at the last tick's sample point
  logic [3:0]  o_grnt, o_cs;
  logic        o_rdy, o_err;
  logic [31:0] o_rd, o_wd;

  bus_arbiter #(.TIMEOUT_CYC(TO), .RESET_PTR(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req(m_req), .m_as(m_as), .m_rw(m_rw), .m_addr(m_addr), .m_wr_data(m_wr_data),
    .m_grnt(m_grnt), .m_rdy(m_rdy), .m_err(m_err), .m_rd_data(m_rd_data),
    .s_as(s_as), .s_rw(s_rw), .s_addr(s_addr), .s_wr_data(s_wr_data), .s_cs(s_cs),
    .s_rdy(s_rdy), .s_rd_data(s_rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mg = 1'b0;
    mo = 0;
    ml = 3;
    mw = -1;
  endtask

  // Check one cycle against the model, then advance both across the rising edge.
  task automatic tick();
    logic [31:0] e_addr, e_wd, e_rd;
    logic [3:0]  e_cs, e_grnt;
    logic [1:0]  sel;
    logic        own_req, own_as, e_as, e_rw, rdy_sel, done;
    #1;
    if (!rst_n) model_reset();
    own_req = mg && m_req[mo];
    own_as  = m_as[mo];
    e_as    = own_req && own_as;
    e_addr  = e_as ? m_addr[32*mo +: 32] : 32'd0;
    e_wd    = e_as ? m_wr_data[32*mo +: 32] : 32'd0;
    e_rw    = e_as && m_rw[mo];
    sel     = e_addr[31:30];
    e_cs    = e_as ? 4'(1 << sel) : 4'd0;
    rdy_sel = s_rdy[sel];
    done    = e_as && (mw >= 0) && (rdy_sel || mw == TO - 1);
    e_rd    = (done && rdy_sel && !e_rw) ? s_rd_data[32*sel +: 32] : 32'd0;
    e_grnt  = mg ? 4'(1 << mo) : 4'd0;
    chk("m_grnt",    32'(m_grnt),  32'(e_grnt));
    chk("s_as",      32'(s_as),    32'(e_as));
    chk("s_rw",      32'(s_rw),    32'(e_rw));
    chk("s_addr",    s_addr,       e_addr);
    chk("s_wr_data", s_wr_data,    e_wd);
    chk("s_cs",      32'(s_cs),    32'(e_cs));
    chk("m_rdy",     32'(m_rdy),   32'(done));
    chk("m_err",     32'(m_err),   32'(done && !rdy_sel));
    chk("m_rd_data", m_rd_data,    e_rd);
    o_grnt = m_grnt; o_cs = s_cs; o_rdy = m_rdy; o_err = m_err; o_rd = m_rd_data; o_wd = s_wr_data;
    @(posedge clk);
    if (rst_n) begin
      if (!mg) begin
        for (int k = 1; k <= 4; k++) begin
          if (!mg && m_req[(ml + k) % 4]) begin
            mg = 1'b1;
            mo = (ml + k) % 4;
            ml = mo;
            mw = -1;
          end
        end
      end else if (!m_req[mo]) begin
        mg = 1'b0;
        mw = -1;
      end else if (mw < 0) begin
        if (own_as) mw = 0;
      end else if (!own_as || done) begin
        mw = -1;
      end else begin
        mw++;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_master(input int i, input logic rw, input logic [31:0] addr, input logic [31:0] wd);
    m_rw[i] = rw;
    m_addr[32*i +: 32] = addr;
    m_wr_data[32*i +: 32] = wd;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(7) == 0) m_req[i] = ~m_req[i];
      if ($urandom_range(3) == 0) m_as[i] = ~m_as[i];
      if ($urandom_range(3) == 0) m_rw[i] = 1'($urandom_range(1));
      if ($urandom_range(5) == 0) m_addr[32*i +: 32] = $urandom;
      m_wr_data[32*i +: 32] = $urandom;
      s_rdy[i] = ($urandom_range(2) == 0);
      s_rd_data[32*i +: 32] = $urandom;
    end
    rst_n = ($urandom_range(299) != 0);
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0;
    m_req = '0; m_as = '0; m_rw = '0; m_addr = '0; m_wr_data = '0;
    s_rdy = '0; s_rd_data = '0;
    model_reset();
    @(negedge clk);
    tick();
    chk("reset_grnt", 32'(o_grnt), 32'd0);
    rst_n = 1'b1;

    // two requesters after reset: master 0 first, gap cycle, then master 1
    m_req = 4'b0011;
    tick();
    tick();
    chk("first_grant", 32'(o_grnt), 32'h1);
    m_req = 4'b0010;
    tick();
    tick();
    chk("gap_cycle", 32'(o_grnt), 32'h0);
    tick();
    chk("second_grant", 32'(o_grnt), 32'h2);

    // master 1 write to slave 1, ready on the third access cycle
    m_as[1] = 1'b1;
    set_master(1, 1'b1, 32'h4000_0010, 32'hDEAD_BEEF);
    tick();
    chk("wr_cs", 32'(o_cs), 32'h2);
    chk("wr_data", o_wd, 32'hDEAD_BEEF);
    pulses = 0;
    tick(); pulses += int'(o_rdy);
    tick(); pulses += int'(o_rdy);
    s_rdy = 4'b0010;
    tick(); pulses += int'(o_rdy);
    chk("wr_err", 32'(o_err), 32'h0);
    s_rdy = '0; m_as = '0;
    tick(); pulses += int'(o_rdy);
    chk("wr_pulses", 32'(pulses), 32'd1);
    m_req = '0;
    tick();

    // master 0 read from slave 0 with immediate ready
    m_req = 4'b0001; m_as = 4'b0001;
    set_master(0, 1'b0, 32'h0000_0100, 32'h0);
    s_rd_data[31:0] = 32'h1234_5678;
    s_rdy = 4'b0001;
    tick();
    tick();
    chk("rd_owned_rdy", 32'(o_rdy), 32'h0);
    tick();
    chk("rd_rdy", 32'(o_rdy), 32'h1);
    chk("rd_data", o_rd, 32'h1234_5678);
    m_req = '0; m_as = '0; s_rdy = '0;
    tick();

    // timeout with only unselected slaves ready
    m_req = 4'b0001; m_as = 4'b0001;
    s_rdy = 4'b1110;
    tick();
    tick();
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("to_rdy", 32'(o_rdy), 32'(c == 4));
      if (c == 4) begin
        chk("to_err", 32'(o_err), 32'h1);
        chk("to_rd", o_rd, 32'h0);
      end
    end
    m_req = '0; m_as = '0; s_rdy = '0;
    tick();

    // asynchronous reset in the middle of an access
    m_req = 4'b0100; m_as = 4'b0100;
    set_master(2, 1'b0, 32'hC000_0000, 32'h0);
    tick();
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_grnt", 32'(m_grnt), 32'h0);
    chk("arst_s_as", 32'(s_as), 32'h0);
    chk("arst_s_cs", 32'(s_cs), 32'h0);
    chk("arst_rdy", 32'(m_rdy), 32'h0);
    tick();
    rst_n = 1'b1;

    // all four requesting, each releases after one access
    m_req = 4'b1111; m_as = 4'b1111; m_rw = 4'b0000; s_rdy = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      tick();
      chk("rr_order", 32'(o_grnt), 32'(1 << (k % 4)));
      tick();
      m_req[k % 4] = 1'b0;
      tick();
      m_req = 4'b1111;
    end

    // random traffic against the model
    m_req = '0; m_as = '0;
    for (int n = 0; n < 2000; n++) begin
      rand_inputs();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, meaning cycles an access may wait for slave ready before error completion (range 1..255).
REQ-002 SHALL have parameter RESET_PTR, default 3, meaning initial round-robin pointer, so master 0 wins first.
REQ-003 SHALL have port clk  input  1  system clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port m_req  input  4  per-master bus request (bit i = master i; 0 = IF, 1 = MEMU, 2-3 spare).
REQ-006 SHALL have port m_as  input  4  per-master address strobe.
REQ-007 SHALL have port m_rw  input  4  per-master direction, 1 = WRITE, 0 = READ.
REQ-008 SHALL have port m_addr  input  128  per-master address, master i at [32i+31:32i].
REQ-009 SHALL have port m_wr_data  input  128  per-master write data, same packing.
REQ-010 SHALL have port m_grnt  output  4  one-hot-or-zero grant, registered.
REQ-011 SHALL have port m_rdy  output  1  completion pulse to current owner.
REQ-012 SHALL have port m_err  output  1  completion was a timeout, valid with m_rdy.
REQ-013 SHALL have port m_rd_data  output  32  read data to owner.
REQ-014 SHALL have port s_as, s_rw  output  1 each  shared slave strobe and direction.
REQ-015 SHALL have port s_addr, s_wr_data  output  32 each  shared slave address and write data.
REQ-016 SHALL have port s_cs  output  4  one-hot slave select, decoded from s_addr[31:30] (slave 0 = RAM, 1 = timer, 2-3 = peripherals).
REQ-017 SHALL have port s_rdy  input  4  per-slave ready.
REQ-018 SHALL have port s_rd_data  input  128  per-slave read data, 32 bits per slave.

Function
REQ-019 SHALL implement FSM states IDLE, OWNED and ACCESS, with a 2-bit owner register, a 2-bit round-robin pointer and an 8-bit timeout counter.
REQ-020 IDLE: when any m_req is set, SHALL pick the first requester searching ptr+1, ptr+2, ptr+3, ptr (mod 4), then register m_grnt[winner]=1, owner=winner, ptr=winner and go to OWNED on the same edge; with no request it SHALL stay IDLE with m_grnt=0.
REQ-021 Grant latency SHALL be 1 cycle from m_req seen in IDLE to m_grnt high.
REQ-022 OWNED: if m_req[owner]=0, SHALL clear m_grnt next edge and go IDLE; requests from other masters SHALL be ignored until IDLE (minimum one grant-free cycle between owners).
REQ-023 OWNED: if m_req[owner]=1 and m_as[owner]=1, SHALL go to ACCESS and clear the counter.
REQ-024 s_as SHALL be combinational, equal to m_as[owner] when state is OWNED or ACCESS and m_req[owner]=1, else 0.
REQ-025 s_addr, s_rw and s_wr_data SHALL be combinational muxes of the owner's signals when s_as=1, else 0.
REQ-026 s_cs SHALL be 0 whenever s_as=0.
REQ-027 ACCESS: when s_rdy[sel]=1 (sel = s_addr[31:30]), m_rdy SHALL be 1 combinationally that cycle, with m_rd_data = s_rd_data[sel] for reads and 0 for writes, m_err=0; state SHALL return to OWNED next edge.
REQ-028 ACCESS: the counter SHALL increment each cycle s_rdy[sel]=0; on the cycle the counter equals TIMEOUT_CYC-1 with no ready, SHALL assert m_rdy=1, m_err=1, m_rd_data=0 and return to OWNED.
REQ-029 ACCESS: if m_req[owner] or m_as[owner] drops before completion, SHALL abort: s_as drops immediately, no m_rdy; go IDLE if req dropped, else OWNED.
REQ-030 Back-to-back accesses SHALL be supported: an owner holding m_as high after completion starts a new ACCESS one cycle later (via OWNED).
REQ-031 m_rdy, m_err and m_rd_data SHALL be 0 outside completion cycles.
REQ-032 s_rdy from unselected slaves SHALL be ignored.

Reset
REQ-033 rst_n low SHALL immediately force state IDLE, m_grnt=0, owner=0, ptr=RESET_PTR, counter=0, and thereby s_as=0, s_cs=0, m_rdy=0, m_err=0, all data outputs 0.
REQ-034 Reset during ACCESS SHALL abandon the access with no completion pulse; the first arbitration after release SHALL use ptr=RESET_PTR.

Verification
REQ-035 After reset, m_req=4'b0011 -> m_grnt=4'b0001 one cycle later; master 0 drops req -> m_grnt=0 for one cycle, then m_grnt=4'b0010.
REQ-036 Master 1 write addr 0x4000_0010, data 0xDEAD_BEEF, s_rdy[1] after 2 cycles -> s_cs=4'b0010, s_wr_data=0xDEAD_BEEF, single m_rdy pulse, m_err=0.
REQ-037 Master 0 read addr 0x0000_0100, s_rd_data slave0=0x1234_5678, s_rdy[0] immediate -> m_rd_data=0x1234_5678 with m_rdy in the first ACCESS cycle.
REQ-038 TIMEOUT_CYC=4, read with s_rdy stuck 0 -> m_rdy=1, m_err=1, m_rd_data=0 on the 4th ACCESS cycle.
REQ-039 All four masters requesting continuously with release after each access -> grant order 0,1,2,3,0.
REQ-040 rst_n pulsed low mid-ACCESS -> s_as=0 and m_grnt=0 asynchronously, no m_rdy, next grant to master 0.
